// File: rtl/univ_shift_seq.sv
// ---------------------------------------------------------------------------
// univ_shift_seq
//
// Sequenced universal shift register. A start command either loads parallel
// data, or performs a multi-step shift/rotate of `count` single-bit steps at
// one step per clock. Progress is reported with `busy` (high while stepping)
// and a one-cycle `done` pulse after every accepted command.
//
// Configuration macro:
//   USHIFT_ROTATE_EN  defined   : modes 5 (ROL) and 6 (ROR) rotate.
//                     undefined : rotate logic is not built; modes 5 and 6
//                                 act as HOLD (straight to DONE, no change).
//
// Parameters:
//   WIDTH  data register width (>= 2)
//   CNT_W  width of the step-count input
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous, active-low reset
//   start     in   command strobe, sampled only in IDLE
//   mode      in   [2:0] 0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ASR, 5 ROL, 6 ROR,
//                  7 reserved (HOLD)
//   count     in   [CNT_W-1:0] number of 1-bit steps
//   data_in   in   [WIDTH-1:0] parallel load value
//   sin       in   serial fill bit for SHL/SHR, sampled on every step
//   data_out  out  [WIDTH-1:0] register contents
//   sout      out  bit shifted/rotated out on the most recent step
//   busy      out  high while stepping
//   done      out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module univ_shift_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] count,
    input  logic [WIDTH-1:0] data_in,
    input  logic             sin,
    output logic [WIDTH-1:0] data_out,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_LOAD = 3'd1,
        OP_SHL  = 3'd2,
        OP_SHR  = 3'd3,
        OP_ASR  = 3'd4,
        OP_ROL  = 3'd5,
        OP_ROR  = 3'd6,
        OP_RSVD = 3'd7
    } op_t;

    state_t           state, state_n;
    op_t              op_q, op_n;
    logic [CNT_W-1:0] remaining, remaining_n;
    logic [WIDTH-1:0] data_n;
    logic             sout_n;
    op_t              op_in;

    assign op_in = op_t'(mode);

    // Modes that enter SHIFT when given a non-zero count. Without the rotate
    // build, ROL/ROR fall into the HOLD path and never reach SHIFT.
    function automatic logic is_step_op(input op_t op);
        case (op)
            OP_SHL, OP_SHR, OP_ASR: is_step_op = 1'b1;
`ifdef USHIFT_ROTATE_EN
            OP_ROL, OP_ROR:         is_step_op = 1'b1;
`endif
            default:                is_step_op = 1'b0;
        endcase
    endfunction

    // Next-state and datapath logic.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned; an unassigned path in always_comb would infer a latch.
        state_n     = state;
        op_n        = op_q;
        remaining_n = remaining;
        data_n      = data_out;
        sout_n      = sout;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (op_in == OP_LOAD) begin
                        data_n  = data_in;
                        state_n = ST_DONE;
                    end else if (is_step_op(op_in) && (count != '0)) begin
                        op_n        = op_in;
                        remaining_n = count;
                        state_n     = ST_SHIFT;
                    end else begin
                        // HOLD, reserved, disabled rotate, or zero count.
                        state_n = ST_DONE;
                    end
                end
            end

            ST_SHIFT: begin
                case (op_q)
                    OP_SHL: begin
                        data_n = {data_out[WIDTH-2:0], sin};
                        sout_n = data_out[WIDTH-1];
                    end
                    OP_SHR: begin
                        data_n = {sin, data_out[WIDTH-1:1]};
                        sout_n = data_out[0];
                    end
                    OP_ASR: begin
                        data_n = {data_out[WIDTH-1], data_out[WIDTH-1:1]};
                        sout_n = data_out[0];
                    end
`ifdef USHIFT_ROTATE_EN
                    OP_ROL: begin
                        data_n = {data_out[WIDTH-2:0], data_out[WIDTH-1]};
                        sout_n = data_out[WIDTH-1];
                    end
                    OP_ROR: begin
                        data_n = {data_out[0], data_out[WIDTH-1:1]};
                        sout_n = data_out[0];
                    end
`endif
                    default: begin
                        data_n = data_out;
                        sout_n = sout;
                    end
                endcase

                remaining_n = remaining - CNT_W'(1);
                if (remaining == CNT_W'(1)) begin
                    state_n = ST_DONE;
                end
            end

            ST_DONE: begin
                // Any start seen here is dropped, not queued.
                state_n = ST_IDLE;
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and output registers. busy/done are registered decodes of the
    // next state so every output comes straight from a flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            op_q      <= OP_HOLD;
            remaining <= '0;
            data_out  <= '0;
            sout      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values computed above, independent of order.
            state     <= state_n;
            op_q      <= op_n;
            remaining <= remaining_n;
            data_out  <= data_n;
            sout      <= sout_n;
            busy      <= (state_n == ST_SHIFT);
            done      <= (state_n == ST_DONE);
        end
    end

endmodule

// File: tb/tb_univ_shift_seq.sv
// ---------------------------------------------------------------------------
// tb_univ_shift_seq
//
// Self-checking bench for univ_shift_seq (WIDTH=16, CNT_W=5). Directed
// vectors from a table, hand-written multi-cycle sequences (start ignored
// while busy, reset mid-shift, reset mid-clock), and random commands
// compared against a closed-form arithmetic model.
// Follows USHIFT_ROTATE_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_univ_shift_seq;

    localparam int W = 16;

`ifdef USHIFT_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          start;
    logic [2:0]    mode;
    logic [4:0]    count;
    logic [W-1:0]  data_in;
    logic          sin;
    logic [W-1:0]  data_out;
    logic          sout;
    logic          busy;
    logic          done;

    int checks;
    int failures;

    univ_shift_seq #(.WIDTH(W), .CNT_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .count    (count),
        .data_in  (data_in),
        .sin      (sin),
        .data_out (data_out),
        .sout     (sout),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one command and follow it to its done pulse. lat counts sampled
    // cycles after the accepting edge up to and including the done cycle
    // (-1 if done never came). done_late is done one cycle after that.
    task automatic run_cmd(input logic [2:0] m, input logic [4:0] k,
                           input logic [W-1:0] din, input logic s,
                           output int lat, output int bcyc,
                           output bit ovl, output logic done_late);
        bit seen;
        lat  = 0;
        bcyc = 0;
        ovl  = 1'b0;
        seen = 1'b0;
        @(negedge clk);
        mode = m; count = k; data_in = din; sin = s; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            lat++;
            if (busy) bcyc++;
            if (busy && done) ovl = 1'b1;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) lat = -1;
        @(negedge clk);
        done_late = done;
    endtask

    // Closed-form result of a whole command, from the operation definitions.
    function automatic void model(input logic [2:0] m, input int k, input logic s,
                                  input logic [W-1:0] din,
                                  input logic [W-1:0] v, input logic so,
                                  output logic [W-1:0] nv, output logic nso,
                                  output bit stepped);
        logic [63:0] ext;
        logic [63:0] fill;
        logic [31:0] dbl;
        int          r;
        nv      = v;
        nso     = so;
        stepped = 1'b0;
        fill    = s ? ((64'd1 << k) - 64'd1) : 64'd0;
        dbl     = {v, v};
        r       = k % W;
        if (m == 3'd1) begin
            nv = din;
        end else if (k > 0) begin
            case (m)
                3'd2: begin
                    ext = ({48'd0, v} << k) | fill;
                    nv = ext[W-1:0]; nso = ext[W]; stepped = 1'b1;
                end
                3'd3: begin
                    ext = (fill << W) | {48'd0, v};
                    nso = ext[k-1]; ext = ext >> k;
                    nv = ext[W-1:0]; stepped = 1'b1;
                end
                3'd4: begin
                    ext = {{48{v[W-1]}}, v};
                    nso = ext[k-1]; ext = ext >> k;
                    nv = ext[W-1:0]; stepped = 1'b1;
                end
                3'd5: if (ROT_EN) begin
                    dbl = dbl >> (W - r);
                    nv = dbl[W-1:0]; nso = nv[0]; stepped = 1'b1;
                end
                3'd6: if (ROT_EN) begin
                    dbl = dbl >> r;
                    nv = dbl[W-1:0]; nso = nv[W-1]; stepped = 1'b1;
                end
                default: ;
            endcase
        end
    endfunction

    typedef struct {
        logic [2:0]   m;
        logic [4:0]   k;
        logic [W-1:0] din;
        logic         s;
        logic [W-1:0] ed;
        logic         es;
        int           elat;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int           lat, bcyc;
        bit           ovl, stepped;
        logic         dl;
        logic [W-1:0] m_data, e_data;
        logic         m_sout, e_sout;
        logic [2:0]   rm;
        logic [4:0]   rk;
        logic [W-1:0] rd;
        logic         rs;

        checks = 0; failures = 0;

        //              mode  k   din      sin  exp_data  sout lat
        tbl[0]  = '{3'd1, 5'd0,  16'hA5C3, 1'b0, 16'hA5C3, 1'b0, 1};
        tbl[1]  = '{3'd2, 5'd4,  16'h0000, 1'b1, 16'h5C3F, 1'b0, 5};
        tbl[2]  = '{3'd1, 5'd0,  16'h8010, 1'b0, 16'h8010, 1'b0, 1};
        tbl[3]  = '{3'd4, 5'd3,  16'h0000, 1'b0, 16'hF002, 1'b0, 4};
        tbl[4]  = '{3'd3, 5'd0,  16'h0000, 1'b1, 16'hF002, 1'b0, 1};
        tbl[5]  = '{3'd1, 5'd0,  16'h8001, 1'b0, 16'h8001, 1'b0, 1};
        tbl[6]  = '{3'd4, 5'd20, 16'h0000, 1'b0, 16'hFFFF, 1'b1, 21};
        tbl[7]  = '{3'd1, 5'd0,  16'h1234, 1'b0, 16'h1234, 1'b1, 1};
        tbl[8]  = '{3'd0, 5'd5,  16'hFFFF, 1'b0, 16'h1234, 1'b1, 1};
        tbl[9]  = '{3'd7, 5'd3,  16'hFFFF, 1'b0, 16'h1234, 1'b1, 1};
`ifdef USHIFT_ROTATE_EN
        tbl[10] = '{3'd5, 5'd16, 16'h0000, 1'b0, 16'h1234, 1'b0, 17};
`else
        tbl[10] = '{3'd5, 5'd16, 16'h0000, 1'b0, 16'h1234, 1'b1, 1};
`endif
        tbl[11] = '{3'd3, 5'd17, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 18};
        tbl[12] = '{3'd2, 5'd3,  16'h0000, 1'b0, 16'hFFF8, 1'b1, 4};
`ifdef USHIFT_ROTATE_EN
        tbl[13] = '{3'd6, 5'd1,  16'h0000, 1'b0, 16'h7FFC, 1'b0, 2};
`else
        tbl[13] = '{3'd6, 5'd1,  16'h0000, 1'b0, 16'hFFF8, 1'b1, 1};
`endif

        // Reset state.
        reset = 1'b0; start = 1'b0; mode = '0; count = '0; data_in = '0; sin = 1'b0;
        #1;
        check("reset data_out", 32'(data_out), 32'h0);
        check("reset sout", 32'(sout), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset done", 32'(done), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Directed table.
        for (int i = 0; i < 14; i++) begin
            run_cmd(tbl[i].m, tbl[i].k, tbl[i].din, tbl[i].s, lat, bcyc, ovl, dl);
            check($sformatf("vec%0d data_out", i), 32'(data_out), 32'(tbl[i].ed));
            check($sformatf("vec%0d sout", i), 32'(sout), 32'(tbl[i].es));
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(tbl[i].elat));
            check($sformatf("vec%0d busy_cycles", i), 32'(bcyc), 32'(tbl[i].elat - 1));
            check($sformatf("vec%0d busy_and_done", i), 32'(ovl), 32'h0);
            check($sformatf("vec%0d done_one_cycle", i), 32'(dl), 32'h0);
        end

        // Random commands against the model.
        m_data = tbl[13].ed;
        m_sout = tbl[13].es;
        for (int i = 0; i < 150; i++) begin
            rm = 3'($urandom_range(0, 7));
            rk = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 4)) : 5'($urandom_range(0, 31));
            rd = 16'($urandom);
            rs = 1'($urandom);
            model(rm, int'(rk), rs, rd, m_data, m_sout, e_data, e_sout, stepped);
            run_cmd(rm, rk, rd, rs, lat, bcyc, ovl, dl);
            check($sformatf("rnd%0d m%0d k%0d data_out", i, rm, rk), 32'(data_out), 32'(e_data));
            check($sformatf("rnd%0d m%0d k%0d sout", i, rm, rk), 32'(sout), 32'(e_sout));
            check($sformatf("rnd%0d latency", i), 32'(lat), stepped ? 32'(rk) + 32'd1 : 32'd1);
            check($sformatf("rnd%0d busy_cycles", i), 32'(bcyc), stepped ? 32'(rk) : 32'd0);
            if (ovl || dl) check($sformatf("rnd%0d handshake", i), {30'd0, ovl, dl}, 32'h0);
            m_data = e_data;
            m_sout = e_sout;
        end

        // start pulsed while busy must be ignored.
        run_cmd(3'd1, 5'd0, 16'hA5C3, 1'b0, lat, bcyc, ovl, dl);
        check("seq1 load", 32'(data_out), 32'hA5C3);
        @(negedge clk);
        mode = 3'd2; count = 5'd4; sin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("seq1 busy after E0", 32'(busy), 32'h1);
        mode = 3'd1; data_in = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mode = 3'd2;
        bcyc = 2; lat = 2;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            lat++;
            if (busy) bcyc++;
        end
        check("seq1 busy_cycles", 32'(bcyc), 32'd4);
        check("seq1 latency", 32'(lat), 32'd5);
        check("seq1 data_out", 32'(data_out), 32'h5C3F);
        check("seq1 sout", 32'(sout), 32'h0);
        bcyc = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (busy || done) bcyc++;
        end
        check("seq1 no queued command", 32'(bcyc), 32'd0);
        check("seq1 data held", 32'(data_out), 32'h5C3F);

        // Reset asserted mid-shift.
        run_cmd(3'd1, 5'd0, 16'hFFFF, 1'b0, lat, bcyc, ovl, dl);
        @(negedge clk);
        mode = 3'd3; count = 5'd8; sin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("seq2 three steps", 32'(data_out), 32'h1FFF);
        #1 reset = 1'b0;
        #1;
        check("seq2 reset data_out", 32'(data_out), 32'h0);
        check("seq2 reset sout", 32'(sout), 32'h0);
        check("seq2 reset busy", 32'(busy), 32'h0);
        check("seq2 reset done", 32'(done), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        run_cmd(3'd1, 5'd0, 16'h00AA, 1'b0, lat, bcyc, ovl, dl);
        check("seq2 load after reset", 32'(data_out), 32'h00AA);
        check("seq2 load latency", 32'(lat), 32'd1);
        check("seq2 load busy", 32'(bcyc), 32'd0);

        // Reset asserted mid-clock with start held high.
        @(negedge clk);
        mode = 3'd1; data_in = 16'h3C3C; start = 1'b1;
        @(posedge clk);
        #1;
        check("seq3 load taken", 32'(data_out), 32'h3C3C);
        #2 reset = 1'b0;
        #1;
        check("seq3 reset data_out", 32'(data_out), 32'h0);
        check("seq3 reset sout+busy+done", {29'd0, sout, busy, done}, 32'h0);
        @(posedge clk);
        #1;
        check("seq3 held in reset", {15'd0, data_out, busy}, 32'h0);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
